// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - mode codes, direction codes and route lookup shared with the motor driver
package line_pkg;

   typedef logic [4:0] state_t;

   localparam state_t MODE_IDLE          = 5'd0;
   localparam state_t MODE_START         = 5'd1;
   localparam state_t MODE_COUNT         = 5'd2;
   localparam state_t MODE_STRAIGHT      = 5'd3;
   localparam state_t MODE_CHOOSE        = 5'd4;
   localparam state_t MODE_TURN_STRAIGHT = 5'd5;
   localparam state_t MODE_TURN_LEFT     = 5'd6;
   localparam state_t MODE_TURN_RIGHT    = 5'd7;
   localparam state_t MODE_STOP          = 5'd30;
   localparam state_t MODE_ERROR         = 5'd31;

   localparam logic [1:0] DIR_STRAIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT     = 2'b01;
   localparam logic [1:0] DIR_RIGHT    = 2'b10;
   localparam logic [1:0] DIR_STOP     = 2'b11;

   // Entries past the end of the 8-slot table read as STOP.
   function automatic logic [1:0] route_entry(input logic [15:0] route, input logic [3:0] idx);
      logic [1:0] entry;
      entry = DIR_STOP;
      for (int i = 0; i < 8; i++) begin
         if (idx == 4'(i)) entry = route[2*i +: 2];
      end
      return entry;
   endfunction

endpackage

// File: rtl/sensor_filter.sv
// rtl/sensor_filter.sv - two-flop synchroniser and stability filter for the IR sensor vector
module sensor_filter #(
   parameter int unsigned FILTER_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sensor,
   output logic [2:0] fs
);

   localparam int unsigned   CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [CW-1:0] cnt;

   // cnt restarts on the edge where sync2 takes a new value, so it holds CNT_LAST
   // only after sync2 has been steady for FILTER_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         cnt   <= '0;
         fs    <= '0;
      end else begin
         sync1 <= sensor;
         sync2 <= sync1;
         if (cnt == CNT_LAST) fs <= sync2;
         if (sync1 != sync2) begin
            cnt <= '0;
         end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/line_mode_fsm.sv
// rtl/line_mode_fsm.sv - line-follower mission sequencer driving the motor driver mode code
module line_mode_fsm
   import line_pkg::*;
#(
   parameter int unsigned COUNT_CYCLES  = 100_000_000,
   parameter int unsigned FILTER_CYCLES = 1000,
   parameter int unsigned LOST_CYCLES   = 50_000_000,
   parameter int unsigned TURN_MIN      = 20_000_000,
   parameter int unsigned TURN_MAX      = 300_000_000,
   parameter int unsigned ROUTE_LEN     = 8,
   parameter logic [15:0] ROUTE         = 16'h0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] sensor,
   output logic [4:0] mode,
   output logic [2:0] route_idx,
   output logic       busy
);

   localparam logic [3:0] IDX_END = 4'(ROUTE_LEN);

   state_t      state;
   state_t      next_state;
   logic [3:0]  idx;
   logic [3:0]  next_idx;
   logic [31:0] timer;
   logic [31:0] lost;
   logic [2:0]  fs;
   logic [1:0]  entry;

   sensor_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_sensor_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .sensor (sensor),
      .fs     (fs)
   );

   assign entry = route_entry(ROUTE, idx);

   always_comb begin
      next_state = state;
      next_idx   = idx;
      if (abort) begin
         next_state = MODE_IDLE;
      end else begin
         case (state)
            MODE_IDLE: if (start) next_state = MODE_START;
            MODE_START: begin
               next_state = MODE_COUNT;
               next_idx   = '0;
            end
            MODE_COUNT: if (timer == 32'(COUNT_CYCLES - 1)) next_state = MODE_STRAIGHT;
            MODE_STRAIGHT: begin
               if (fs == 3'b111) next_state = MODE_CHOOSE;
               else if (fs == 3'b000 && lost == 32'(LOST_CYCLES - 1)) next_state = MODE_ERROR;
            end
            MODE_CHOOSE: begin
               if (idx >= IDX_END || entry == DIR_STOP) begin
                  next_state = MODE_STOP;
               end else begin
                  case (entry)
                     DIR_LEFT:  next_state = MODE_TURN_LEFT;
                     DIR_RIGHT: next_state = MODE_TURN_RIGHT;
                     default:   next_state = MODE_TURN_STRAIGHT;
                  endcase
                  next_idx = idx + 4'd1;
               end
            end
            MODE_TURN_STRAIGHT, MODE_TURN_LEFT, MODE_TURN_RIGHT: begin
               if (timer >= 32'(TURN_MIN - 1) && fs == 3'b010) next_state = MODE_STRAIGHT;
               else if (timer == 32'(TURN_MAX - 1)) next_state = MODE_ERROR;
            end
            MODE_STOP, MODE_ERROR: if (start) next_state = MODE_IDLE;
            default: next_state = MODE_ERROR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MODE_IDLE;
         idx   <= '0;
         timer <= '0;
         lost  <= '0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         timer <= (next_state != state) ? 32'd0 : timer + 32'd1;
         lost  <= (state == MODE_STRAIGHT && fs == 3'b000) ? lost + 32'd1 : 32'd0;
      end
   end

   assign mode      = state;
   // An exhausted 8-entry route reports the last slot; idx itself saturates at 8.
   assign route_idx = idx[3] ? 3'd7 : idx[2:0];
   assign busy      = (state >= MODE_START) && (state <= MODE_TURN_RIGHT);

endmodule

// File: tb/tb_line_mode_fsm.sv
// tb/tb_line_mode_fsm.sv - scoreboard bench for line_mode_fsm against a behavioural mission model
module tb_line_mode_fsm;

   localparam int          COUNT_C = 10;
   localparam int          FILT    = 3;
   localparam int          LOST_C  = 20;
   localparam int          TMIN    = 5;
   localparam int          TMAX    = 50;
   localparam int          RLEN    = 2;
   localparam logic [15:0] ROUTE_V = 16'h0009;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] sensor = 3'b000;
   logic [4:0] mode;
   logic [2:0] route_idx;
   logic       busy;

   line_mode_fsm #(
      .COUNT_CYCLES  (COUNT_C),
      .FILTER_CYCLES (FILT),
      .LOST_CYCLES   (LOST_C),
      .TURN_MIN      (TMIN),
      .TURN_MAX      (TMAX),
      .ROUTE_LEN     (RLEN),
      .ROUTE         (ROUTE_V)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .sensor    (sensor),
      .mode      (mode),
      .route_idx (route_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      int cyc;
      int mode;
      int idx;
   } exp_t;
   exp_t sb[$];

   int         m_mode = 0;
   int         m_idx  = 0;
   int         m_time = 0;
   int         m_lost = 0;
   logic [2:0] m_fs   = 3'b000;
   logic [2:0] hist[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int route_dir(input int i);
      if (i >= 8) return 3;
      return (int'(ROUTE_V) >> (2 * i)) & 3;
   endfunction

   // Mission rules evaluated once per clock edge from the inputs present at that edge.
   task automatic model_step();
      int         nm;
      int         ni;
      int         dir;
      logic [2:0] samp;
      bit         steady;
      nm = m_mode;
      ni = m_idx;
      if (!rst_n) begin
         nm     = 0;
         ni     = 0;
         m_time = 0;
         m_lost = 0;
         m_fs   = 3'b000;
         hist.delete();
         for (int i = 0; i < FILT + 2; i++) hist.push_front(3'b000);
      end else begin
         if (abort) begin
            nm = 0;
         end else begin
            case (m_mode)
               0: if (start) nm = 1;
               1: begin nm = 2; ni = 0; end
               2: if (m_time == COUNT_C - 1) nm = 3;
               3: begin
                  if (m_fs == 3'b111) nm = 4;
                  else if (m_fs == 3'b000 && m_lost + 1 == LOST_C) nm = 31;
               end
               4: begin
                  dir = route_dir(m_idx);
                  if (m_idx == RLEN || dir == 3) nm = 30;
                  else begin nm = 5 + dir; ni = m_idx + 1; end
               end
               5, 6, 7: begin
                  if (m_time >= TMIN - 1 && m_fs == 3'b010) nm = 3;
                  else if (m_time == TMAX - 1) nm = 31;
               end
               30, 31: if (start) nm = 0;
               default: nm = 31;
            endcase
         end
         m_lost = (m_mode == 3 && m_fs == 3'b000) ? m_lost + 1 : 0;
         m_time = (nm != m_mode) ? 0 : m_time + 1;
         samp = sensor;
         hist.push_front(samp);
         if (hist.size() > 16) void'(hist.pop_back());
         // Accept the sample taken two edges ago once the last FILT such samples agree.
         steady = 1'b1;
         for (int i = 3; i <= FILT + 1; i++) if (hist[i] != hist[2]) steady = 1'b0;
         if (steady) m_fs = hist[2];
      end
      if (nm != m_mode || ni != m_idx) sb.push_back('{cyc: cyc, mode: nm, idx: ni});
      m_mode = nm;
      m_idx  = ni;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         model_step();
      end
   end

   initial begin
      int   last_mode;
      int   last_idx;
      exp_t e;
      last_mode = 0;
      last_idx  = 0;
      forever begin
         @(negedge clk);
         if (int'(mode) != last_mode || int'(route_idx) != last_idx) begin
            check("sb_has_expectation", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("sb_mode", int'(mode), e.mode);
               check("sb_route_idx", int'(route_idx), e.idx);
               check("sb_cycle", cyc, e.cyc);
               check("sb_busy", int'(busy), int'(e.mode >= 1 && e.mode <= 7));
            end
            last_mode = int'(mode);
            last_idx  = int'(route_idx);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_mode(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (int'(mode) != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(mode), target);
   endtask

   initial begin
      int r;
      int len;
      sensor = 3'b010;
      tick(3);
      check("reset_mode", int'(mode), 0);
      check("reset_route_idx", int'(route_idx), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick(3);

      pulse_start();
      check("start_mode", int'(mode), 1);
      check("start_busy", int'(busy), 1);
      tick(1);
      check("count_first", int'(mode), 2);
      tick(9);
      check("count_last", int'(mode), 2);
      tick(1);
      check("count_done", int'(mode), 3);

      sensor = 3'b111;
      wait_mode(4, 20, "route_choose1");
      sensor = 3'b010;
      tick(1);
      check("route_turn_left", int'(mode), 6);
      wait_mode(3, 30, "route_straight1");
      sensor = 3'b111;
      wait_mode(4, 20, "route_choose2");
      tick(1);
      check("route_turn_right", int'(mode), 7);
      sensor = 3'b010;
      wait_mode(3, 30, "route_straight2");
      sensor = 3'b111;
      wait_mode(4, 20, "route_choose3");
      tick(1);
      check("route_stop", int'(mode), 30);
      check("route_idx_end", int'(route_idx), 2);
      pulse_start();
      check("stop_start_idle", int'(mode), 0);

      sensor = 3'b010;
      pulse_start();
      wait_mode(3, 30, "lost_enter_straight");
      sensor = 3'b111;
      tick(2);
      sensor = 3'b010;
      tick(10);
      check("glitch_no_choose", int'(mode), 3);
      pulse_start();
      tick(1);
      check("start_ignored_straight", int'(mode), 3);
      sensor = 3'b000;
      wait_mode(31, 40, "lost_error");
      pulse_start();
      check("error_start_idle", int'(mode), 0);

      sensor = 3'b010;
      pulse_start();
      wait_mode(3, 30, "timeout_enter_straight");
      sensor = 3'b111;
      wait_mode(4, 20, "timeout_choose");
      tick(1);
      check("timeout_turn_left", int'(mode), 6);
      wait_mode(31, 70, "turn_timeout_error");
      pulse_start();

      sensor = 3'b010;
      pulse_start();
      wait_mode(3, 30, "abort_enter_straight");
      sensor = 3'b111;
      wait_mode(4, 20, "abort_choose1");
      sensor = 3'b010;
      wait_mode(3, 30, "abort_straight");
      sensor = 3'b111;
      wait_mode(7, 30, "abort_turn_right");
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_idle", int'(mode), 0);
      check("abort_busy", int'(busy), 0);

      sensor = 3'b010;
      pulse_start();
      tick(5);
      check("rst_mid_count", int'(mode), 2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mode", int'(mode), 0);
      check("async_rst_idx", int'(route_idx), 0);
      check("async_rst_busy", int'(busy), 0);
      tick(2);
      rst_n = 1'b1;
      pulse_start();
      check("restart_start", int'(mode), 1);
      tick(1);
      check("restart_count", int'(mode), 2);
      tick(9);
      check("restart_count_last", int'(mode), 2);
      tick(1);
      check("restart_straight", int'(mode), 3);

      for (int s = 0; s < 450; s++) begin
         r = $urandom_range(0, 99);
         if (r < 10)      sensor = 3'b000;
         else if (r < 45) sensor = 3'b010;
         else if (r < 75) sensor = 3'b111;
         else             sensor = 3'($urandom_range(0, 7));
         len = $urandom_range(1, 12);
         start = ($urandom_range(0, 5) == 0);
         abort = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 149) == 0) #1 rst_n = 1'b0;
         tick(1);
         start = 1'b0;
         abort = 1'b0;
         rst_n = 1'b1;
         tick(len - 1);
      end

      tick(1);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
